// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch sequencing FSM, button conditioning and tick prescaler (optional debounce: STOPWATCH_DEBOUNCE_EN)
module stopwatch_ctrl #(
    parameter int unsigned CLK_HZ          = 100_000_000,
    parameter int unsigned TICK_HZ         = 100,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        btn_start_stop,
    input  logic        btn_reset,
    input  logic [1:0]  mode_sel,
    input  logic [3:0]  init_val_one,
    input  logic [3:0]  init_val_two,
    input  logic [3:0]  digit0,
    input  logic [3:0]  digit1,
    input  logic [3:0]  digit2,
    input  logic [3:0]  digit3,
    output logic        count_tick,
    output logic        count_dir,
    output logic        load,
    output logic [15:0] load_value,
    output logic        run,
    output logic        done,
    output logic [1:0]  state
);
    localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    // bit 1 = reset button, bit 0 = start/stop button
    logic [1:0] btn_raw, sync1, sync2, lvl, lvl_q, ev;
    logic       ss_ev, rst_ev;

    assign btn_raw = {btn_reset, btn_start_stop};
    assign ss_ev   = ev[0];
    assign rst_ev  = ev[1];

    // two-flop synchronizer for both raw buttons
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

`ifdef STOPWATCH_DEBOUNCE_EN
    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic [DW-1:0] db_cnt [2];
    logic [1:0]    db_lvl;

    // a new level is accepted only after it has held for DEBOUNCE_CYCLES cycles
    always_ff @(posedge clock) begin
        if (reset) begin
            db_lvl    <= '0;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == db_lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_lvl[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign lvl = db_lvl;
`else
    assign lvl = sync2;
`endif

    // registered rising-edge detector: one single-cycle event per press
    always_ff @(posedge clock) begin
        if (reset) begin
            lvl_q <= '0;
            ev    <= '0;
        end else begin
            lvl_q <= lvl;
            ev    <= lvl & ~lvl_q;
        end
    end

    function automatic logic [3:0] clamp_bcd(input logic [3:0] v);
        return (v > 4'd9) ? 4'd9 : v;
    endfunction

    logic [15:0] sel_value;

    // preset selected by the live mode switch, captured only on a load
    always_comb begin
        case (mode_sel)
            2'b00:   sel_value = 16'h0000;
            2'b10:   sel_value = 16'h9999;
            default: sel_value = {clamp_bcd(init_val_two), clamp_bcd(init_val_one), 8'h00};
        endcase
    end

    state_t        state_q;
    logic [PW-1:0] presc;
    logic [1:0]    mode_q;
    logic [15:0]   value_q;
    logic          boot_q, load_q, tick_q, run_q, done_q;
    logic          boot, terminal;

    // boot_q survives reset so the first cycle after release carries the initial load
    assign boot     = boot_q & ~reset;
    assign terminal = mode_q[1] ? ({digit3, digit2, digit1, digit0} == 16'h0000)
                                : ({digit3, digit2, digit1, digit0} == 16'h9999);

    // main sequencer: loads, run/pause/done transitions and tick prescaler
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            presc   <= '0;
            mode_q  <= 2'b00;
            value_q <= 16'h0000;
            boot_q  <= 1'b1;
            load_q  <= 1'b0;
            tick_q  <= 1'b0;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            boot_q <= 1'b0;
            load_q <= 1'b0;
            tick_q <= 1'b0;
            if (boot_q) begin
                mode_q  <= mode_sel;
                value_q <= sel_value;
            end else if (rst_ev) begin
                state_q <= IDLE;
                run_q   <= 1'b0;
                done_q  <= 1'b0;
                presc   <= '0;
                load_q  <= 1'b1;
                mode_q  <= mode_sel;
                value_q <= sel_value;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (ss_ev) begin
                            state_q <= RUN;
                            run_q   <= 1'b1;
                            presc   <= '0;
                        end else if (mode_sel != mode_q) begin
                            load_q  <= 1'b1;
                            mode_q  <= mode_sel;
                            value_q <= sel_value;
                        end
                    end
                    RUN: begin
                        if (ss_ev) begin
                            state_q <= PAUSE;
                            run_q   <= 1'b0;
                        end else if (presc == PRESC_LAST) begin
                            presc <= '0;
                            if (terminal) begin
                                state_q <= DONE;
                                run_q   <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                tick_q <= 1'b1;
                            end
                        end else begin
                            presc <= presc + 1'b1;
                        end
                    end
                    PAUSE: begin
                        if (ss_ev) begin
                            state_q <= RUN;
                            run_q   <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign load       = load_q | boot;
    assign load_value = boot ? sel_value : value_q;
    assign count_dir  = boot ? ~mode_sel[1] : ~mode_q[1];
    assign count_tick = tick_q;
    assign run        = run_q;
    assign done       = done_q;
    assign state      = state_q;
endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Sequencing controller for the stopwatch BCD counter datapath. Converts start/stop and reset push-buttons into clean single-cycle events. Runs the IDLE/RUN/PAUSE/DONE state machine and generates the 0.01 s count tick from the system clock. Drives the counter's load, direction and tick controls, and watches the counter's digit feedback for terminal count. It sits between the board I/O and the counter, below the top-level `stopwatch`.

## Interface
- `CLK_HZ`, 100_000_000, system clock frequency.
- `TICK_HZ`, 100, count tick rate; `TICK_DIV = CLK_HZ/TICK_HZ` must be ≥ 2.
- `DEBOUNCE_CYCLES`, 1_000_000, stable-level cycles required per button (10 ms at 100 MHz).

- `clock` in 1: system clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high.
- `btn_start_stop` in 1: raw, asynchronous button.
- `btn_reset` in 1: raw, asynchronous button.
- `mode_sel` in 2: 00 = up from 0000, 01 = up from init, 10 = down from 9999, 11 = down from init.
- `init_val_one` in 4: BCD, preset for digit2.
- `init_val_two` in 4: BCD, preset for digit3.
- `digit0`..`digit3` in 4 each: counter feedback, digit0 is the LSD.
- `count_tick` out 1: one-cycle pulse; counter steps once per pulse.
- `count_dir` out 1: 1 = up, 0 = down.
- `load` out 1: one-cycle pulse; counter loads `load_value`.
- `load_value` out 16: {digit3, digit2, digit1, digit0}.
- `run` out 1: high in RUN.
- `done` out 1: high in DONE.
- `state` out 2: IDLE = 00, RUN = 01, PAUSE = 10, DONE = 11.

## Operation
- Both buttons pass through a 2-flop synchronizer, then an optional debouncer, then a rising-edge detector. Each press produces one single-cycle event: `ss_ev` or `rst_ev`.
- **Load:**
  - A load happens on the first cycle after `reset` deasserts, on every `rst_ev`, and on any `mode_sel` change while in IDLE.
  - The load latches `mode_sel` into `mode_q`. The running count uses `mode_q`, so `mode_sel` changes in RUN, PAUSE or DONE are ignored.
  - `count_dir = ~mode_q[1]`.
  - `load_value`:
    - Mode 00: 0x0000.
    - Mode 10: 0x9999.
    - Modes 01 and 11: {clamp(init_val_two), clamp(init_val_one), 0x0, 0x0}, where clamp maps values > 9 to 9.
- **FSM:**
  - IDLE + `ss_ev` → RUN; the prescaler is cleared.
  - RUN + `ss_ev` → PAUSE; the prescaler value is held.
  - PAUSE + `ss_ev` → RUN; the prescaler resumes from its held value.
  - RUN + terminal → DONE. Terminal is digits == 9999 when `count_dir` = 1, and 0000 when `count_dir` = 0. It is evaluated at the prescaler wrap cycle; on that cycle no tick is issued.
  - DONE + `ss_ev` → ignored.
  - Any state + `rst_ev` → IDLE with a load pulse.
  - `rst_ev` and `ss_ev` in the same cycle: reset wins and `ss_ev` is dropped.
- Prescaler: counts 0..`TICK_DIV`-1 only in RUN. The wrap cycle asserts `count_tick` unless terminal.
- A start from an already-terminal load (e.g. mode 10 after a down count reached 0000 is not applicable; mode 00 loaded as 0000 is not terminal for up counting) goes to DONE at the first wrap.

## Timing
- Reset values:
  - `state` = IDLE.
  - `count_tick`, `load`, `run`, `done` = 0.
  - `count_dir` = 1.
  - `load_value` = 0x0000.
  - `mode_q` = 00.
  - Prescaler = 0.
- `load` is asserted in cycle R+1, where R is the last cycle with `reset` high.
- Button latency from raw edge to event:
  - 3 cycles without the debouncer.
  - 3 + `DEBOUNCE_CYCLES` cycles with it.
- State updates the cycle after the event. `run`, `done` and `state` are registered and change together.
- First `count_tick` occurs exactly `TICK_DIV` cycles after entering RUN from IDLE. Subsequent ticks are spaced exactly `TICK_DIV` cycles apart.
- `load` and `count_tick` are never high in the same cycle.
- `load_value` and `count_dir` are stable from the load cycle until the next load.
- Digit feedback is assumed valid one cycle after `count_tick`. Since `TICK_DIV` ≥ 2, the terminal check always sees updated digits.

## Configuration
- `STOPWATCH_DEBOUNCE_EN` defined: each synchronized button must hold a new level for `DEBOUNCE_CYCLES` consecutive cycles before the edge detector sees it. Glitches shorter than that produce no event.
- Undefined: the synchronizer output feeds the edge detector directly, and `DEBOUNCE_CYCLES` is unused.

## Test plan
All scenarios use `CLK_HZ`=1000, `TICK_HZ`=100 (`TICK_DIV`=10) and no debounce unless stated.
- Reset, then release with mode 00 → `load`=1 for one cycle with `load_value`=0x0000 and `count_dir`=1. Then `ss_ev` → RUN, with ticks at +10, +20, +30 cycles.
- Mode 01 with init_two=5, init_one=12 → `load_value`=0x5900. Toggle start in RUN, wait 25 cycles, toggle start again → PAUSE with no ticks; the tick phase resumes where it stopped.
- Mode 11 from 0x0100 with the counter model attached → exactly 100 ticks, then DONE, `done`=1, no further ticks. `ss_ev` in DONE → state stays 11.
- `btn_reset` and `btn_start_stop` pressed in the same cycle while in RUN → IDLE plus one `load` pulse, and no RUN.
- Change `mode_sel` 00→10 in IDLE → reload 0x9999 with `count_dir`=0. The same change in RUN → no load, direction unchanged.
- With `STOPWATCH_DEBOUNCE_EN` and `DEBOUNCE_CYCLES`=8: a 5-cycle pulse gives no event; a 12-cycle press gives exactly one `ss_ev`, 11 cycles after the raw edge.
